// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the instruction size in bytes.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of {pc, data} fetch results.
// Ports: clk/rst, i_push/i_pc/i_data, i_pop, i_flush, o_pc/o_data, o_count, o_empty.
module fetch_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_pc,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [W-1:0]           o_pc,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_pc   [DEPTH];
  logic [W-1:0]  r_data [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_pc    = r_pc[r_rd];
  assign o_data  = r_data[r_rd];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr]   <= i_pc;
      r_data[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction fetch with redirect/flush.
// Ports: clk/rst, redirect_*, imem_req_*, imem_rsp_*, inst_*, fetch_misaligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                         WORD_BITWIDTH = 32,
  parameter logic [WORD_BITWIDTH-1:0]   RESET_VECTOR  = '0,
  parameter int                         BUF_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [WORD_BITWIDTH-1:0] redirect_base,
  input  logic [WORD_BITWIDTH-1:0] redirect_offset,
  input  logic                     redirect_clear_lsb,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [WORD_BITWIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [WORD_BITWIDTH-1:0] imem_rsp_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [WORD_BITWIDTH-1:0] inst_data,
  output logic [WORD_BITWIDTH-1:0] inst_pc,
  output logic                     fetch_misaligned
);

  localparam int W  = WORD_BITWIDTH;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [W-1:0]  STEP  = W'(INST_BYTES);
  localparam logic [CW:0]   LIMIT = (CW+1)'(BUF_DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [W-1:0]  r_req_pc;
  logic [W-1:0]  r_rsp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_rsp_cnt;
  logic [CW:0]   w_credit;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_target;
  logic          w_rsp_ok;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  assign w_sum    = redirect_base + redirect_offset;
  assign w_target = {w_sum[W-1:1], w_sum[0] & ~redirect_clear_lsb};

  // A response with nothing in flight is a protocol error: ignore it.
  assign w_rsp_ok  = imem_rsp_valid && (r_out != '0);
  assign w_rsp_cnt = CW'(w_rsp_ok);

  // In-flight plus buffered never exceeds the buffer size, so pushes
  // always find room.
  assign w_credit = {1'b0, r_out} + {1'b0, w_count};

  assign imem_req_valid = !rst && !redirect_valid &&
                          (r_state == RUN) && (w_credit < LIMIT);
  assign imem_req_addr  = r_req_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign w_push = w_rsp_ok && !redirect_valid && (r_state == RUN);
  assign inst_valid = !w_empty;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  assign fetch_misaligned = (r_state == HALT);

  fetch_buffer #(
    .W     (W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pc    (r_rsp_pc),
    .i_data  (imem_rsp_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_pc    (inst_pc),
    .o_data  (inst_data),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    if (redirect_valid) begin
      // Everything still in flight after this cycle is stale.
      w_drop_nxt = r_out - w_rsp_cnt;
      if (w_target[1:0] != 2'b00)
        w_state_nxt = HALT;
      else if (w_drop_nxt != '0)
        w_state_nxt = FLUSH;
      else
        w_state_nxt = RUN;
    end else if (r_state == FLUSH) begin
      if (w_rsp_ok && (r_drop != '0))
        w_drop_nxt = r_drop - 1'b1;
      if (w_drop_nxt == '0)
        w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_req_pc <= RESET_VECTOR;
      r_rsp_pc <= RESET_VECTOR;
      r_out    <= '0;
      r_drop   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      r_out   <= r_out + CW'(w_fire) - w_rsp_cnt;
      if (redirect_valid) begin
        r_req_pc <= w_target;
        r_rsp_pc <= w_target;
      end else begin
        if (w_fire) r_req_pc <= r_req_pc + STEP;
        if (w_push) r_rsp_pc <= r_rsp_pc + STEP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a fixed-latency memory.
// Expected {pc,data} pushed on each accepted request, popped on delivery.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_base = '0;
  logic [31:0] redirect_offset = '0;
  logic        redirect_clear_lsb = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  fetch_unit #(
    .WORD_BITWIDTH (32),
    .RESET_VECTOR  (32'h0),
    .BUF_DEPTH     (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .redirect_valid     (redirect_valid),
    .redirect_base      (redirect_base),
    .redirect_offset    (redirect_offset),
    .redirect_clear_lsb (redirect_clear_lsb),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .inst_data          (inst_data),
    .inst_pc            (inst_pc),
    .fetch_misaligned   (fetch_misaligned)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  sb[$];
  pend_t pend[$];
  int    checks = 0;
  int    failures = 0;
  int    ncyc = 0;
  int    mem_lat = 1;
  int    n_pops = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Memory model and scoreboard. Inputs only change at posedge+1, so
  // values seen here are what the DUT samples at the next edge.
  always @(negedge clk) begin
    exp_t  e;
    pend_t p;
    ncyc++;
    if (rst) begin
      pend.delete();
      sb.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (redirect_valid) begin
        sb.delete();
      end else if (inst_valid && inst_ready) begin
        checks++;
        n_pops++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got pc=%h data=%h, none expected",
                   inst_pc, inst_data);
        end else begin
          e = sb.pop_front();
          if (inst_pc !== e.pc || inst_data !== e.data) begin
            failures++;
            $display("FAIL sb_inst got pc=%h data=%h want pc=%h data=%h",
                     inst_pc, inst_data, e.pc, e.data);
          end
        end
      end
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        p = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(p.addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      if (imem_req_valid && imem_req_ready) begin
        p.addr = imem_req_addr;
        p.due  = ncyc + mem_lat;
        pend.push_back(p);
        e.pc   = imem_req_addr;
        e.data = memf(imem_req_addr);
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] b, input logic [31:0] o,
                          input logic c);
    redirect_base = b;
    redirect_offset = o;
    redirect_clear_lsb = c;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want 0", sb.size());
    end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 ||
        fetch_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs got req=%b iv=%b mis=%b want 0 0 0",
               imem_req_valid, inst_valid, fetch_misaligned);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_req got v=%b a=%h want 1 00000000",
               imem_req_valid, imem_req_addr);
    end
    step();
    drain();
  endtask

  task automatic test_stream();
    int p0;
    mem_lat = 1;
    do_reset();
    p0 = n_pops;
    repeat (30) step();
    checks++;
    if (n_pops - p0 < 25) begin
      failures++;
      $display("FAIL stream_rate got %0d want >=25", n_pops - p0);
    end
    drain();
  endtask

  task automatic test_stall();
    int peak;
    mem_lat = 1;
    do_reset();
    repeat (5) step();
    inst_ready = 1'b0;
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sb.size() > peak) peak = sb.size();
    end
    checks++;
    if (peak > 4 || sb.size() != 4 || inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_credit got peak=%0d now=%0d iv=%b want 4 4 1",
               peak, sb.size(), inst_valid);
    end
    inst_ready = 1'b1;
    repeat (8) step();
    drain();
  endtask

  task automatic test_redirect_flush();
    bit ok;
    mem_lat = 3;
    do_reset();
    repeat (8) step();
    checks++;
    if (pend.size() != 3) begin
      failures++;
      $display("FAIL flush_inflight got %0d want 3", pend.size());
    end
    redirect(32'h100, 32'h20, 1'b0);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_req got %b want 0", imem_req_valid);
    end
    wait_valid(ok);
    checks++;
    if (!ok || inst_pc !== 32'h120) begin
      failures++;
      $display("FAIL flush_first_pc got ok=%b pc=%h want 1 00000120",
               ok, inst_pc);
    end
    repeat (6) step();
    drain();
    mem_lat = 1;
  endtask

  task automatic test_misaligned();
    bit ok;
    int bad;
    mem_lat = 1;
    do_reset();
    repeat (4) step();
    redirect(32'h203, 32'h0, 1'b1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 ||
          inst_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_state got %0d bad cycles want 0", bad);
    end
    redirect(32'h40, 32'h0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || inst_pc !== 32'h40 || fetch_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume got ok=%b pc=%h mis=%b want 1 00000040 0",
               ok, inst_pc, fetch_misaligned);
    end
    repeat (4) step();
    drain();
  endtask

  task automatic test_wrap();
    bit ok;
    mem_lat = 1;
    do_reset();
    repeat (3) step();
    redirect(32'hFFFF_FFF8, 32'h10, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || inst_pc !== 32'h8) begin
      failures++;
      $display("FAIL wrap_sum got ok=%b pc=%h want 1 00000008", ok, inst_pc);
    end
    redirect(32'hFFFF_FFFC, 32'h0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || inst_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top got ok=%b pc=%h want 1 fffffffc", ok, inst_pc);
    end
    step();
    wait_valid(ok);
    checks++;
    if (!ok || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap_zero got ok=%b pc=%h want 1 00000000", ok, inst_pc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int p0;
    mem_lat = 2;
    do_reset();
    p0 = n_pops;
    for (int i = 0; i < 300; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    checks++;
    if (n_pops - p0 < 100) begin
      failures++;
      $display("FAIL b2b_rate got %0d want >=100", n_pops - p0);
    end
    drain();
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
